// File: rtl/soc_addr_map_unit_pkg.sv
// Address-map types and the power-on rule table for the runtime-programmable
// SoC decoder.
package ariane_soc;

  localparam int unsigned MapNrRules   = 12;
  localparam int unsigned MapAddrWidth = 64;
  localparam int unsigned MapIdxWidth  = 4;

  // Bit positions inside the 3-bit attribute field.
  typedef enum int unsigned {
    MapAttrCached = 0,
    MapAttrExec   = 1,
    MapAttrIdem   = 2
  } map_attr_e;

  typedef struct packed {
    logic [MapAddrWidth-1:0] base;
    logic [MapAddrWidth-1:0] length;
    logic [MapIdxWidth-1:0]  idx;
    logic [2:0]              attr;
    logic                    en;
  } map_rule_t;

  localparam logic [63:0] DebugBase    = 64'h0000_0000;
  localparam logic [63:0] DebugLength  = 64'h0000_1000;
  localparam logic [63:0] ROMBase      = 64'h0001_0000;
  localparam logic [63:0] ROMLength    = 64'h0001_0000;
  localparam logic [63:0] CLINTBase    = 64'h0200_0000;
  localparam logic [63:0] CLINTLength  = 64'h000C_0000;
  localparam logic [63:0] PLICBase     = 64'h0C00_0000;
  localparam logic [63:0] PLICLength   = 64'h0400_0000;
  localparam logic [63:0] UARTBase     = 64'h1000_0000;
  localparam logic [63:0] UARTLength   = 64'h0000_1000;
  localparam logic [63:0] TimerBase    = 64'h1800_0000;
  localparam logic [63:0] TimerLength  = 64'h0000_1000;
  localparam logic [63:0] SPIBase      = 64'h2000_0000;
  localparam logic [63:0] SPILength    = 64'h0080_0000;
  localparam logic [63:0] EthernetBase = 64'h3000_0000;
  localparam logic [63:0] EthernetLength = 64'h0001_0000;
  localparam logic [63:0] GPIOBase     = 64'h4000_0000;
  localparam logic [63:0] GPIOLength   = 64'h0000_1000;
  localparam logic [63:0] DRAMBase     = 64'h8000_0000;
  localparam logic [63:0] DRAMLength   = 64'h4000_0000;

  localparam logic [2:0] AttrDram   = 3'b111;
  localparam logic [2:0] AttrDebug  = 3'b110;
  localparam logic [2:0] AttrRom    = 3'b011;
  localparam logic [2:0] AttrDevice = 3'b000;

  // DRAM sits at rule 0 so the common cached path wins any overlap; last two slots are spare.
  localparam map_rule_t MapResetRules [MapNrRules] = '{
    '{base: DRAMBase,     length: DRAMLength,     idx: 4'd0,  attr: AttrDram,   en: 1'b1},
    '{base: DebugBase,    length: DebugLength,    idx: 4'd1,  attr: AttrDebug,  en: 1'b1},
    '{base: ROMBase,      length: ROMLength,      idx: 4'd2,  attr: AttrRom,    en: 1'b1},
    '{base: CLINTBase,    length: CLINTLength,    idx: 4'd3,  attr: AttrDevice, en: 1'b1},
    '{base: PLICBase,     length: PLICLength,     idx: 4'd4,  attr: AttrDevice, en: 1'b1},
    '{base: UARTBase,     length: UARTLength,     idx: 4'd5,  attr: AttrDevice, en: 1'b1},
    '{base: TimerBase,    length: TimerLength,    idx: 4'd6,  attr: AttrDevice, en: 1'b1},
    '{base: SPIBase,      length: SPILength,      idx: 4'd7,  attr: AttrDevice, en: 1'b1},
    '{base: EthernetBase, length: EthernetLength, idx: 4'd8,  attr: AttrDevice, en: 1'b1},
    '{base: GPIOBase,     length: GPIOLength,     idx: 4'd9,  attr: AttrDevice, en: 1'b1},
    '{base: 64'h0,        length: 64'h0,          idx: 4'd10, attr: AttrDevice, en: 1'b0},
    '{base: 64'h0,        length: 64'h0,          idx: 4'd11, attr: AttrDevice, en: 1'b0}
  };

  function automatic map_rule_t map_reset_rule(input int unsigned i);
    map_rule_t r;
    if (i < MapNrRules) begin
      r = MapResetRules[i[3:0]];
    end else begin
      r = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/soc_addr_map_unit_match.sv
// Single-rule comparator. The offset is taken at full address width so a rule
// ending at the top of the address space cannot wrap onto low addresses.
module addr_rule_match
  import ariane_soc::*;
(
  input  map_rule_t               rule,
  input  logic [MapAddrWidth-1:0] addr,
  output logic                    hit
);

  logic [MapAddrWidth-1:0] offset_s;

  assign offset_s = addr - rule.base;
  assign hit      = rule.en && (addr >= rule.base) && (offset_s < rule.length);

endmodule

// File: rtl/soc_addr_map_unit.sv
// Runtime-programmable address decoder: rule table with write lock, S1 per-rule
// match vector, S2 lowest-index priority pick, valid/ready on both ends.
module soc_addr_map_unit
  import ariane_soc::*;
#(
  parameter  int unsigned NrRules      = 12,
  parameter  int unsigned AddrWidth    = 64,
  parameter  int unsigned SlvIdxWidth  = 4,
  parameter  int unsigned DefaultSlave = 0,
  localparam int unsigned CfgWidth     = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [SlvIdxWidth-1:0] rsp_idx_o,
  output logic [2:0]             rsp_attr_o,
  output logic                   rsp_miss_o,
  input  logic                   cfg_we_i,
  input  logic [CfgWidth-1:0]    cfg_rule_i,
  input  map_rule_t              cfg_data_i,
  input  logic                   cfg_lock_i,
  output logic                   cfg_err_o,
  output logic                   locked_o
);

  localparam logic [CfgWidth:0] NrRulesExt = (CfgWidth + 1)'(NrRules);

  map_rule_t               table_r [NrRules];
  logic                    locked_r;
  logic                    cfg_err_r;
  logic                    wr_ok_s;

  logic [MapAddrWidth-1:0] addr_s;
  logic [NrRules-1:0]      match_s;
  logic                    req_ready_s;
  logic                    s2_en_s;

  logic                    s1_valid_r;
  logic [NrRules-1:0]      s1_match_r;

  logic                    pick_hit_s;
  logic [MapIdxWidth-1:0]  pick_idx_s;
  logic [2:0]              pick_attr_s;

  logic                    s2_valid_r;
  logic [SlvIdxWidth-1:0]  s2_idx_r;
  logic [2:0]              s2_attr_r;
  logic                    s2_miss_r;

  assign addr_s      = MapAddrWidth'(req_addr_i);
  assign wr_ok_s     = cfg_we_i && !locked_r && ({1'b0, cfg_rule_i} < NrRulesExt);
  assign s2_en_s     = !s2_valid_r || rsp_ready_i;
  assign req_ready_s = !s1_valid_r || s2_en_s;

  for (genvar g = 0; g < NrRules; g++) begin : g_rule
    addr_rule_match u_match (
      .rule (table_r[g]),
      .addr (addr_s),
      .hit  (match_s[g])
    );
  end

  // Rule table, lock and write-reject pulse; a same-cycle write lands before the lock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NrRules; i++) begin
        table_r[i] <= map_reset_rule(i);
      end
      locked_r  <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NrRules; i++) begin
        if (wr_ok_s && (cfg_rule_i == i[CfgWidth-1:0])) begin
          table_r[i] <= cfg_data_i;
        end
      end
      locked_r  <= locked_r | cfg_lock_i;
      cfg_err_r <= cfg_we_i & ~wr_ok_s;
    end
  end

  // Lowest-index hit wins: scan from the top so lower rules overwrite the pick.
  always_comb begin
    pick_hit_s  = |s1_match_r;
    pick_idx_s  = '0;
    pick_attr_s = 3'b000;
    for (int i = NrRules - 1; i >= 0; i--) begin
      pick_idx_s  = s1_match_r[i] ? table_r[i].idx  : pick_idx_s;
      pick_attr_s = s1_match_r[i] ? table_r[i].attr : pick_attr_s;
    end
  end

  // Two-stage pipeline; each stage loads only when the next one is empty or draining.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_r <= 1'b0;
      s1_match_r <= '0;
      s2_valid_r <= 1'b0;
      s2_idx_r   <= '0;
      s2_attr_r  <= 3'b000;
      s2_miss_r  <= 1'b0;
    end else begin
      if (req_ready_s) begin
        s1_valid_r <= req_valid_i;
        if (req_valid_i) begin
          s1_match_r <= match_s;
        end
      end
      if (s2_en_s) begin
        s2_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          s2_miss_r <= !pick_hit_s;
          s2_idx_r  <= pick_hit_s ? SlvIdxWidth'(pick_idx_s) : SlvIdxWidth'(DefaultSlave);
          s2_attr_r <= pick_hit_s ? pick_attr_s : 3'b000;
        end
      end
    end
  end

  assign req_ready_o = req_ready_s;
  assign rsp_valid_o = s2_valid_r;
  assign rsp_idx_o   = s2_idx_r;
  assign rsp_attr_o  = s2_attr_r;
  assign rsp_miss_o  = s2_miss_r;
  assign cfg_err_o   = cfg_err_r;
  assign locked_o    = locked_r;

endmodule

// File: tb/tb_soc_addr_map_unit.sv
// Self-checking bench: vector table over the reset map plus hand sequences for
// latency, backpressure, overlap, top-of-space, lock, bad index and reset.
module tb_soc_addr_map_unit;
  import ariane_soc::*;

  typedef struct {
    logic [63:0] addr;
    logic [3:0]  idx;
    logic [2:0]  attr;
    logic        miss;
  } vec_t;

  logic        clk;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_addr_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [3:0]  rsp_idx_o;
  logic [2:0]  rsp_attr_o;
  logic        rsp_miss_o;
  logic        cfg_we_i;
  logic [3:0]  cfg_rule_i;
  map_rule_t   cfg_data_i;
  logic        cfg_lock_i;
  logic        cfg_err_o;
  logic        locked_o;

  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];
  vec_t vecs[10];

  soc_addr_map_unit dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_idx_o   (rsp_idx_o),
    .rsp_attr_o  (rsp_attr_o),
    .rsp_miss_o  (rsp_miss_o),
    .cfg_we_i    (cfg_we_i),
    .cfg_rule_i  (cfg_rule_i),
    .cfg_data_i  (cfg_data_i),
    .cfg_lock_i  (cfg_lock_i),
    .cfg_err_o   (cfg_err_o),
    .locked_o    (locked_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk_vec(input logic [63:0] a, input logic [3:0] i,
                                  input logic [2:0] at, input logic m);
    vec_t v;
    v.addr = a; v.idx = i; v.attr = at; v.miss = m;
    return v;
  endfunction

  function automatic map_rule_t mk_rule(input logic [63:0] b, input logic [63:0] l,
                                        input logic [3:0] i, input logic [2:0] at, input logic e);
    map_rule_t r;
    r.base = b; r.length = l; r.idx = i; r.attr = at; r.en = e;
    return r;
  endfunction

  // Scoreboard: compare each consumed response against the oldest expectation.
  always @(negedge clk) begin
    vec_t e;
    if (!rst_i && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got idx %0h expected no response", rsp_idx_o);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("rsp_idx@%0h", e.addr), 64'(rsp_idx_o), 64'(e.idx));
        check($sformatf("rsp_attr@%0h", e.addr), 64'(rsp_attr_o), 64'(e.attr));
        check($sformatf("rsp_miss@%0h", e.addr), 64'(rsp_miss_o), 64'(e.miss));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input vec_t v);
    bit ok;
    ok = 1'b0;
    req_valid_i = 1'b1;
    req_addr_i  = v.addr;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got req_ready 0 expected 1 for %0h", v.addr);
    end else begin
      exp_q.push_back(v);
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input int unsigned rule, input map_rule_t data,
                           input logic lock, input logic exp_err, input string name);
    cfg_we_i   = 1'b1;
    cfg_rule_i = rule[3:0];
    cfg_data_i = data;
    cfg_lock_i = lock;
    @(posedge clk); #1;
    cfg_we_i   = 1'b0;
    cfg_lock_i = 1'b0;
    @(negedge clk);
    check({name, "_err"}, 64'(cfg_err_o), 64'(exp_err));
    @(negedge clk);
    check({name, "_err_clr"}, 64'(cfg_err_o), 64'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = mk_vec(64'h8000_1000, 4'd0, 3'b111, 1'b0);
    vecs[1] = mk_vec(64'h0500_0000, 4'd0, 3'b000, 1'b1);
    vecs[2] = mk_vec(64'h1000_0004, 4'd5, 3'b000, 1'b0);
    vecs[3] = mk_vec(64'hBFFF_FFFF, 4'd0, 3'b111, 1'b0);
    vecs[4] = mk_vec(64'hC000_0000, 4'd0, 3'b000, 1'b1);
    vecs[5] = mk_vec(64'h0000_0FFF, 4'd1, 3'b110, 1'b0);
    vecs[6] = mk_vec(64'h0000_1000, 4'd0, 3'b000, 1'b1);
    vecs[7] = mk_vec(64'h0001_FFFF, 4'd2, 3'b011, 1'b0);
    vecs[8] = mk_vec(64'h0002_0000, 4'd0, 3'b000, 1'b1);
    vecs[9] = mk_vec(64'h207F_FFFF, 4'd7, 3'b000, 1'b0);

    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = 64'h0; rsp_ready_i = 1'b1;
    cfg_we_i = 1'b0; cfg_rule_i = 4'd0; cfg_data_i = '0; cfg_lock_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    @(negedge clk);
    check("rst_req_ready", 64'(req_ready_o), 64'h1);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
    check("rst_rsp_idx",   64'(rsp_idx_o),   64'h0);
    check("rst_rsp_attr",  64'(rsp_attr_o),  64'h0);
    check("rst_rsp_miss",  64'(rsp_miss_o),  64'h0);
    check("rst_cfg_err",   64'(cfg_err_o),   64'h0);
    check("rst_locked",    64'(locked_o),    64'h0);
    @(posedge clk); #1;

    // Two-cycle latency on the DRAM hit
    send(vecs[0]);
    @(negedge clk);
    check("latency_n1_valid", 64'(rsp_valid_o), 64'h0);
    @(negedge clk);
    check("latency_n2_valid", 64'(rsp_valid_o), 64'h1);
    @(posedge clk); #1;
    drain();

    for (int i = 0; i < 10; i++) send(vecs[i]);
    drain();

    // Backpressure: A and B fill both stages, C must wait
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_addr_i  = 64'h4000_0000;
    @(negedge clk);
    check("bp_ready_a", 64'(req_ready_o), 64'h1);
    exp_q.push_back(mk_vec(64'h4000_0000, 4'd9, 3'b000, 1'b0));
    @(posedge clk); #1;
    req_addr_i = 64'h0500_0000;
    @(negedge clk);
    check("bp_ready_b", 64'(req_ready_o), 64'h1);
    exp_q.push_back(mk_vec(64'h0500_0000, 4'd0, 3'b000, 1'b1));
    @(posedge clk); #1;
    req_addr_i = 64'h0000_0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_stall_ready", 64'(req_ready_o), 64'h0);
      check("bp_hold_valid",  64'(rsp_valid_o), 64'h1);
      check("bp_hold_idx",    64'(rsp_idx_o),   64'h9);
      check("bp_hold_miss",   64'(rsp_miss_o),  64'h0);
    end
    @(posedge clk); #1;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    check("bp_ready_c", 64'(req_ready_o), 64'h1);
    exp_q.push_back(mk_vec(64'h0000_0010, 4'd1, 3'b110, 1'b0));
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    drain();

    // Overlap: rule 3 beats rule 5 until disabled
    cfg_write(3, mk_rule(64'h2000_0000, 64'h1000, 4'd3, 3'b001, 1'b1), 1'b0, 1'b0, "wr_r3");
    cfg_write(5, mk_rule(64'h2000_0000, 64'h1000, 4'd5, 3'b100, 1'b1), 1'b0, 1'b0, "wr_r5");
    send(mk_vec(64'h2000_0800, 4'd3, 3'b001, 1'b0));
    drain();
    cfg_write(3, mk_rule(64'h2000_0000, 64'h1000, 4'd3, 3'b001, 1'b0), 1'b0, 1'b0, "wr_r3_off");
    send(mk_vec(64'h2000_0800, 4'd5, 3'b100, 1'b0));
    drain();

    // Rule touching the top of the address space must not wrap to 0
    cfg_write(10, mk_rule(64'hFFFF_FFFF_FFFF_F000, 64'h1000, 4'd10, 3'b010, 1'b1),
              1'b0, 1'b0, "wr_top");
    send(mk_vec(64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 3'b010, 1'b0));
    send(mk_vec(64'h0, 4'd1, 3'b110, 1'b0));
    drain();

    cfg_write(12, mk_rule(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd12, 3'b111, 1'b1),
              1'b0, 1'b1, "wr_oob");

    // Write and lock together: write lands, then table freezes
    cfg_write(9, mk_rule(64'h4000_0000, 64'h1000, 4'd11, 3'b001, 1'b1), 1'b1, 1'b0, "wr_and_lock");
    check("locked_set", 64'(locked_o), 64'h1);
    send(mk_vec(64'h4000_0000, 4'd11, 3'b001, 1'b0));
    drain();
    cfg_write(1, mk_rule(64'h0, 64'h1000, 4'd12, 3'b111, 1'b1), 1'b0, 1'b1, "wr_locked");
    send(mk_vec(64'h0000_0100, 4'd1, 3'b110, 1'b0));
    drain();

    // Reset with a request in S1 and a write in the reset cycle
    req_valid_i = 1'b1;
    req_addr_i  = 64'h8000_0000;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    rst_i       = 1'b1;
    cfg_we_i    = 1'b1;
    cfg_rule_i  = 4'd2;
    cfg_data_i  = mk_rule(64'h0, 64'h0, 4'd2, 3'b000, 1'b0);
    @(posedge clk); #1;
    rst_i    = 1'b0;
    cfg_we_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_valid",  64'(rsp_valid_o), 64'h0);
      check("post_rst_locked", 64'(locked_o),    64'h0);
      check("post_rst_err",    64'(cfg_err_o),   64'h0);
    end
    @(posedge clk); #1;
    send(mk_vec(64'h0001_0000, 4'd2, 3'b011, 1'b0));
    send(mk_vec(64'h4000_0000, 4'd9, 3'b000, 1'b0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
